// File: rtl/mcc_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, function codes,
// ALU operation codes, FSM state encodings and the decoded-instruction record.
package mcc_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BLTZ = 6'b000001;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_WB   = 3'b011,
    S_MEM  = 3'b100,
    S_HALT = 3'b110,
    S_ERR  = 3'b111
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_BLTZ, C_J, C_HALT, C_ILL
  } iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic       rtype;
    logic [2:0] aluop;
    logic       alusrca;
    logic       alusrcb;
    logic       extsel;
  } dec_t;

endpackage

// File: rtl/mcc_decode.sv
// Combinational instruction decode: op/func to instruction class, ALU function
// and datapath operand selects. Unknown opcodes or R-type functions map to C_ILL.
module mcc_decode
  import mcc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output dec_t       dec
);

  always_comb begin
    dec         = '0;
    dec.cls     = C_ILL;
    dec.rtype   = 1'b0;
    dec.aluop   = ALU_AND;
    dec.alusrca = 1'b0;
    dec.alusrcb = 1'b0;
    dec.extsel  = 1'b0;
    case (op)
      OP_R: begin
        dec.rtype = 1'b1;
        dec.cls   = C_ALU;
        case (func)
          FN_ADD: dec.aluop = ALU_ADD;
          FN_SUB: dec.aluop = ALU_SUB;
          FN_AND: dec.aluop = ALU_AND;
          FN_OR:  dec.aluop = ALU_OR;
          FN_SLL: begin
            dec.aluop   = ALU_SLL;
            dec.alusrca = 1'b1;
          end
          default: dec.cls = C_ILL;
        endcase
      end
      OP_ADDI: begin
        dec.cls = C_ALU; dec.aluop = ALU_ADD; dec.alusrcb = 1'b1; dec.extsel = 1'b1;
      end
      OP_ANDI: begin
        dec.cls = C_ALU; dec.aluop = ALU_AND; dec.alusrcb = 1'b1;
      end
      OP_ORI: begin
        dec.cls = C_ALU; dec.aluop = ALU_OR; dec.alusrcb = 1'b1;
      end
      OP_SLTI: begin
        dec.cls = C_ALU; dec.aluop = ALU_SLT; dec.alusrcb = 1'b1; dec.extsel = 1'b1;
      end
      OP_LW: begin
        dec.cls = C_LW; dec.aluop = ALU_ADD; dec.alusrcb = 1'b1; dec.extsel = 1'b1;
      end
      OP_SW: begin
        dec.cls = C_SW; dec.aluop = ALU_ADD; dec.alusrcb = 1'b1; dec.extsel = 1'b1;
      end
      OP_BEQ: begin
        dec.cls = C_BEQ; dec.aluop = ALU_SUB; dec.extsel = 1'b1;
      end
      OP_BNE: begin
        dec.cls = C_BNE; dec.aluop = ALU_SUB; dec.extsel = 1'b1;
      end
      OP_BLTZ: begin
        dec.cls = C_BLTZ; dec.aluop = ALU_SUB;
      end
      OP_J:    dec.cls = C_J;
      OP_HALT: dec.cls = C_HALT;
      default: dec.cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU controller: sequences IF/ID/EXE/MEM/WB, drives datapath strobes,
// waits on mem_ready with a timeout, counts retired instructions, latches halt/error.
module multi_cycle_control
  import mcc_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int ICNT_W      = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               sign,
  input  logic               mem_ready,
  output logic               PCWre,
  output logic [1:0]         PCSrc,
  output logic               IRWre,
  output logic               RegDst,
  output logic               RegWre,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic               mRD,
  output logic               mWR,
  output logic               DBDataSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         state,
  output logic [ICNT_W-1:0]  instr_cnt,
  output logic               halted,
  output logic               err
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     st_q, st_d;
  logic [7:0] wcnt_q;
  logic [2:0] aluop_int;
  logic       taken;
  dec_t       dec;

  mcc_decode u_decode (
    .op   (op),
    .func (func),
    .dec  (dec)
  );

  assign state = st_q;
  assign ALUOp = ALUOP_W'(aluop_int);

  always_comb begin
    case (dec.cls)
      C_BEQ:   taken = zero;
      C_BNE:   taken = ~zero;
      C_BLTZ:  taken = sign;
      default: taken = 1'b0;
    endcase
  end

  // Next state and strobes; HALT/ERR fall through to the all-zero defaults.
  always_comb begin
    st_d      = st_q;
    PCWre     = 1'b0;
    PCSrc     = 2'b00;
    IRWre     = 1'b0;
    RegDst    = 1'b0;
    RegWre    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    aluop_int = 3'b000;
    case (st_q)
      S_IF: begin
        IRWre = 1'b1;
        st_d  = S_ID;
      end
      S_ID: begin
        case (dec.cls)
          C_HALT: st_d = S_HALT;
          C_ILL:  st_d = S_ERR;
          C_J: begin
            PCWre = 1'b1;
            PCSrc = 2'b10;
            st_d  = S_IF;
          end
          default: st_d = S_EXE;
        endcase
      end
      S_EXE: begin
        aluop_int = dec.aluop;
        ALUSrcA   = dec.alusrca;
        ALUSrcB   = dec.alusrcb;
        ExtSel    = dec.extsel;
        case (dec.cls)
          C_BEQ, C_BNE, C_BLTZ: begin
            PCWre = 1'b1;
            PCSrc = taken ? 2'b01 : 2'b00;
            st_d  = S_IF;
          end
          C_LW, C_SW: st_d = S_MEM;
          default:    st_d = S_WB;
        endcase
      end
      S_MEM: begin
        mRD = (dec.cls == C_LW);
        mWR = (dec.cls == C_SW);
        if (mem_ready) begin
          if (dec.cls == C_SW) begin
            PCWre = 1'b1;
            st_d  = S_IF;
          end else begin
            st_d = S_WB;
          end
        end else if (wcnt_q == WAIT_LAST) begin
          st_d = S_ERR;
        end
      end
      S_WB: begin
        RegWre    = 1'b1;
        DBDataSrc = (dec.cls == C_LW);
        RegDst    = dec.rtype;
        PCWre     = 1'b1;
        st_d      = S_IF;
      end
      default: st_d = st_q;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      st_q      <= S_IF;
      wcnt_q    <= '0;
      instr_cnt <= '0;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      st_q <= st_d;
      // Counter sits at zero outside MEM, so every MEM entry starts a fresh wait.
      if (st_q == S_MEM) wcnt_q <= wcnt_q + 8'd1;
      else               wcnt_q <= '0;
      if (PCWre) instr_cnt <= instr_cnt + ICNT_W'(1);
      if (st_d == S_HALT) halted <= 1'b1;
      if (st_d == S_ERR)  err    <= 1'b1;
    end
  end

endmodule
